// File: rtl/physics_pkg.sv
// ----------------------------------------------------------------------------
// physics_pkg
// Shared constants and types for the physics step scheduler slice.
//   NUM_PINS      : number of bowling pins tracked per step
//   VEL_W         : width of one velocity component (two's complement)
//   PIN_IDX_W     : width of a pin index
//   sched_state_t : step scheduler FSM states
// ----------------------------------------------------------------------------
package physics_pkg;

    localparam int NUM_PINS  = 10;
    localparam int VEL_W     = 16;
    localparam int PIN_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_COLL = 2'd1,
        UPDATE   = 2'd2,
        DONE     = 2'd3
    } sched_state_t;

endpackage

// File: rtl/physics_step_scheduler_step_timer.sv
// ----------------------------------------------------------------------------
// step_timer
// Free-running step-rate counter. Counts 0..TICK_PERIOD-1 while enabled and
// flags the last count as a tick; disabling forces the count back to 0.
// Ports:
//   clk_in    in  system clock
//   rst_in    in  asynchronous active-low reset
//   enable_in in  count enable; low holds the count at 0
//   tick      out high while count == TICK_PERIOD-1 and enabled
// ----------------------------------------------------------------------------
module step_timer #(
    parameter int TICK_PERIOD = 1500000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic enable_in,
    output logic tick
);

    localparam int CW = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_PERIOD - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count <= '0;
        end else if (!enable_in || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = enable_in && (count == LAST);

endmodule

// File: rtl/physics_step_scheduler.sv
// ----------------------------------------------------------------------------
// physics_step_scheduler
// Runs one physics step per timer tick: launches the collision datapath,
// waits (bounded) for its result, latches per-pin hits and velocities, then
// streams one update per hit pin (ascending index) to the motion integrator.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for a step tick
//   RUN_COLL | collision datapath running, waiting for done or timeout
//   UPDATE   | offering latched pin updates over valid/ready
//   DONE     | one-cycle end-of-step pulse
//
// Ports:
//   clk_in, rst_in              clock, asynchronous active-low reset
//   enable_in                   game running (gates the step timer)
//   clear_in                    clear sticky hit/error flags
//   coll_valid_out              collision datapath run request (level)
//   coll_done_in                collision result strobe
//   coll_pins_hit_in            per-pin hit flags
//   coll_vx_in, coll_vy_in      per-pin velocities, pin i at [i*VEL_W +: VEL_W]
//   upd_valid_out/upd_ready_in  update handshake
//   upd_pin_out, upd_vx_out,
//   upd_vy_out                  update payload
//   pins_hit_out                sticky OR of hits since clear
//   step_done_out               end-of-step pulse
//   timeout_err_out             sticky: collision done missed
//   overrun_err_out             sticky: tick arrived while busy
//   busy_out                    FSM not IDLE
// ----------------------------------------------------------------------------
module physics_step_scheduler
    import physics_pkg::*;
#(
    parameter int TICK_PERIOD  = 1500000,
    parameter int COLL_TIMEOUT = 16
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      enable_in,
    input  logic                      clear_in,
    output logic                      coll_valid_out,
    input  logic                      coll_done_in,
    input  logic [NUM_PINS-1:0]       coll_pins_hit_in,
    input  logic [NUM_PINS*VEL_W-1:0] coll_vx_in,
    input  logic [NUM_PINS*VEL_W-1:0] coll_vy_in,
    output logic                      upd_valid_out,
    input  logic                      upd_ready_in,
    output logic [PIN_IDX_W-1:0]      upd_pin_out,
    output logic [VEL_W-1:0]          upd_vx_out,
    output logic [VEL_W-1:0]          upd_vy_out,
    output logic [NUM_PINS-1:0]       pins_hit_out,
    output logic                      step_done_out,
    output logic                      timeout_err_out,
    output logic                      overrun_err_out,
    output logic                      busy_out
);

    localparam int TW = $clog2(COLL_TIMEOUT + 1);

    sched_state_t         state, state_nxt;
    logic [TW-1:0]        tmo_cnt;
    logic [NUM_PINS-1:0]  hit_mask;
    logic [VEL_W-1:0]     vx_lat [NUM_PINS];
    logic [VEL_W-1:0]     vy_lat [NUM_PINS];
    logic [VEL_W-1:0]     vx_in_arr [NUM_PINS];
    logic [VEL_W-1:0]     vy_in_arr [NUM_PINS];
    logic                 tick;
    logic                 coll_fire;
    logic                 tmo_fire;
    logic                 accept;
    logic [NUM_PINS-1:0]  search_mask;
    logic [PIN_IDX_W-1:0] next_pin;
    logic                 next_any;

    step_timer #(.TICK_PERIOD(TICK_PERIOD)) u_step_timer (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .enable_in (enable_in),
        .tick      (tick)
    );

    for (genvar g = 0; g < NUM_PINS; g++) begin : g_unpack
        assign vx_in_arr[g] = coll_vx_in[g*VEL_W +: VEL_W];
        assign vy_in_arr[g] = coll_vy_in[g*VEL_W +: VEL_W];
    end

    assign coll_fire = (state == RUN_COLL) && coll_done_in;
    assign tmo_fire  = (state == RUN_COLL) && !coll_done_in &&
                       (tmo_cnt == TW'(COLL_TIMEOUT - 1));
    assign accept    = (state == UPDATE) && upd_ready_in;

    // One priority encoder serves both the first pin at latch time and the
    // next pin after an accept (current pin masked out of the remaining set).
    always_comb begin
        if (state == RUN_COLL) begin
            search_mask = coll_pins_hit_in;
        end else begin
            search_mask = hit_mask & ~(NUM_PINS'(1) << upd_pin_out);
        end
        next_pin = '0;
        next_any = 1'b0;
        for (int i = NUM_PINS - 1; i >= 0; i--) begin
            if (search_mask[i]) begin
                next_pin = PIN_IDX_W'(i);
                next_any = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (tick) state_nxt = RUN_COLL;
            RUN_COLL: begin
                if (coll_done_in)  state_nxt = next_any ? UPDATE : DONE;
                else if (tmo_fire) state_nxt = DONE;
            end
            UPDATE:   if (upd_ready_in && !next_any) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= IDLE;
            tmo_cnt         <= '0;
            hit_mask        <= '0;
            coll_valid_out  <= 1'b0;
            upd_valid_out   <= 1'b0;
            step_done_out   <= 1'b0;
            busy_out        <= 1'b0;
            upd_pin_out     <= '0;
            upd_vx_out      <= '0;
            upd_vy_out      <= '0;
            pins_hit_out    <= '0;
            timeout_err_out <= 1'b0;
            overrun_err_out <= 1'b0;
            for (int i = 0; i < NUM_PINS; i++) begin
                vx_lat[i] <= '0;
                vy_lat[i] <= '0;
            end
        end else begin
            state          <= state_nxt;
            // Outputs are decoded from the next state so they are flops.
            coll_valid_out <= (state_nxt == RUN_COLL);
            upd_valid_out  <= (state_nxt == UPDATE);
            step_done_out  <= (state_nxt == DONE);
            busy_out       <= (state_nxt != IDLE);

            tmo_cnt <= (state == RUN_COLL) ? tmo_cnt + 1'b1 : '0;

            if (coll_fire) begin
                hit_mask    <= coll_pins_hit_in;
                vx_lat      <= vx_in_arr;
                vy_lat      <= vy_in_arr;
                upd_pin_out <= next_pin;
                upd_vx_out  <= vx_in_arr[next_pin];
                upd_vy_out  <= vy_in_arr[next_pin];
            end else if (accept) begin
                hit_mask <= search_mask;
                if (next_any) begin
                    upd_pin_out <= next_pin;
                    upd_vx_out  <= vx_lat[next_pin];
                    upd_vy_out  <= vy_lat[next_pin];
                end
            end

            // New hits win over a coincident clear.
            if (coll_fire) begin
                pins_hit_out <= (clear_in ? '0 : pins_hit_out) | coll_pins_hit_in;
            end else if (clear_in) begin
                pins_hit_out <= '0;
            end

            // Error sets win over a coincident clear.
            if (tmo_fire)      timeout_err_out <= 1'b1;
            else if (clear_in) timeout_err_out <= 1'b0;

            if (tick && state != IDLE) overrun_err_out <= 1'b1;
            else if (clear_in)         overrun_err_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_physics_step_scheduler.sv
module tb_physics_step_scheduler;
    import physics_pkg::*;

    localparam int TP = 12;
    localparam int CT = 16;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic enable_in = 1'b0;
    logic clear_in = 1'b0;
    logic coll_done_in = 1'b0;
    logic upd_ready_in = 1'b0;
    logic [NUM_PINS-1:0] coll_pins_hit_in = '0;
    logic [NUM_PINS*VEL_W-1:0] coll_vx_in = '0;
    logic [NUM_PINS*VEL_W-1:0] coll_vy_in = '0;

    logic coll_valid_out, upd_valid_out, step_done_out;
    logic timeout_err_out, overrun_err_out, busy_out;
    logic [PIN_IDX_W-1:0] upd_pin_out;
    logic [VEL_W-1:0] upd_vx_out, upd_vy_out;
    logic [NUM_PINS-1:0] pins_hit_out;

    physics_step_scheduler #(.TICK_PERIOD(TP), .COLL_TIMEOUT(CT)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .clear_in(clear_in),
        .coll_valid_out(coll_valid_out), .coll_done_in(coll_done_in),
        .coll_pins_hit_in(coll_pins_hit_in), .coll_vx_in(coll_vx_in), .coll_vy_in(coll_vy_in),
        .upd_valid_out(upd_valid_out), .upd_ready_in(upd_ready_in),
        .upd_pin_out(upd_pin_out), .upd_vx_out(upd_vx_out), .upd_vy_out(upd_vy_out),
        .pins_hit_out(pins_hit_out), .step_done_out(step_done_out),
        .timeout_err_out(timeout_err_out), .overrun_err_out(overrun_err_out),
        .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int r1, dcyc, rdone;

    logic [VEL_W-1:0]    vx_m [NUM_PINS];
    logic [VEL_W-1:0]    vy_m [NUM_PINS];
    logic [NUM_PINS-1:0] cur_hits = '0;
    logic [NUM_PINS-1:0] m_hits = '0;
    bit m_tmo = 0;
    bit m_ovr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic set_stim(input logic [NUM_PINS-1:0] hits);
        cur_hits = hits;
        coll_pins_hit_in = hits;
        for (int i = 0; i < NUM_PINS; i++) begin
            coll_vx_in[i*VEL_W +: VEL_W] = vx_m[i];
            coll_vy_in[i*VEL_W +: VEL_W] = vy_m[i];
        end
    endtask

    task automatic rand_vel();
        for (int i = 0; i < NUM_PINS; i++) begin
            vx_m[i] = VEL_W'($urandom);
            vy_m[i] = VEL_W'($urandom);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_coll_valid"}, coll_valid_out, 0);
        check({tag, "_upd_valid"}, upd_valid_out, 0);
        check({tag, "_upd_pin"}, upd_pin_out, 0);
        check({tag, "_upd_vx"}, upd_vx_out, 0);
        check({tag, "_upd_vy"}, upd_vy_out, 0);
        check({tag, "_pins_hit"}, pins_hit_out, 0);
        check({tag, "_step_done"}, step_done_out, 0);
        check({tag, "_timeout"}, timeout_err_out, 0);
        check({tag, "_overrun"}, overrun_err_out, 0);
        check({tag, "_busy"}, busy_out, 0);
    endtask

    task automatic check_flags();
        check("pins_hit", pins_hit_out, m_hits);
        check("timeout_err", timeout_err_out, m_tmo);
        check("overrun_err", overrun_err_out, m_ovr);
    endtask

    // Raise enable; the first launch is TP edges later.
    task automatic launch(input bit keep_en);
        int n = 0;
        enable_in = 1'b1;
        while (!coll_valid_out && n < TP + 4) begin
            clk_step();
            n++;
        end
        check("launch_latency", n, TP);
        r1 = cyc;
        if (!keep_en) enable_in = 1'b0;
    endtask

    task automatic collide(input int d, input bit tmo, input bit clr);
        int limit = tmo ? CT : d;
        for (int j = 0; j < limit; j++) begin
            check("coll_valid_hold", coll_valid_out, 1);
            check("busy_hold", busy_out, 1);
            clk_step();
        end
        if (!tmo) begin
            check("coll_valid_at_done", coll_valid_out, 1);
            coll_done_in = 1'b1;
            clear_in = clr;
            dcyc = cyc;
            clk_step();
            coll_done_in = 1'b0;
            clear_in = 1'b0;
            if (clr) begin
                m_hits = '0;
                m_tmo = 0;
                m_ovr = 0;
            end
            m_hits = m_hits | cur_hits;
        end else begin
            m_tmo = 1;
            dcyc = cyc - 1;
        end
        check("coll_valid_drop", coll_valid_out, 0);
        check("pins_hit_latch", pins_hit_out, m_hits);
        check("timeout_flag", timeout_err_out, m_tmo);
    endtask

    task automatic updates(input logic [NUM_PINS-1:0] mask, input int stall, input int pct);
        int q[$];
        int n = 0;
        bit fin = 0;
        for (int i = 0; i < NUM_PINS; i++) if (mask[i]) q.push_back(i);
        while (!fin && n < 100) begin
            if (q.size() > 0) begin
                check("upd_valid", upd_valid_out, 1);
                check("upd_pin", upd_pin_out, q[0]);
                check("upd_vx", upd_vx_out, vx_m[q[0]]);
                check("upd_vy", upd_vy_out, vy_m[q[0]]);
                check("step_done_early", step_done_out, 0);
                check("busy_update", busy_out, 1);
            end else begin
                check("upd_valid_end", upd_valid_out, 0);
                check("step_done", step_done_out, 1);
                rdone = cyc;
                fin = 1;
            end
            if (!fin) begin
                if (stall > 0) begin
                    upd_ready_in = 1'b0;
                    stall--;
                end else begin
                    upd_ready_in = ($urandom_range(0, 99) < pct);
                end
                if (upd_ready_in) void'(q.pop_front());
            end
            clk_step();
            n++;
        end
        upd_ready_in = 1'b0;
        check("update_bound", fin, 1);
        check("step_done_pulse", step_done_out, 0);
        check("idle_after_step", busy_out, 0);
    endtask

    initial begin
        for (int i = 0; i < NUM_PINS; i++) begin
            vx_m[i] = '0;
            vy_m[i] = '0;
        end
        #1;
        check_all_zero("reset");
        clk_step();
        clk_step();
        rst_in = 1'b1;

        // Two hits, fixed payloads, ready always high.
        vx_m[0] = 16'h0010; vy_m[0] = 16'h0007;
        vx_m[2] = 16'hFFF0; vy_m[2] = 16'h8001;
        set_stim(10'h005);
        launch(0);
        collide(4, 0, 0);
        updates(10'h005, 0, 100);
        check("done_latency_k2", rdone - dcyc, 3);
        check_flags();

        // Empty hit mask: straight to DONE.
        rand_vel();
        set_stim(10'h000);
        launch(0);
        collide(3, 0, 0);
        updates(10'h000, 0, 100);
        check("done_latency_k0", rdone - dcyc, 1);
        check_flags();

        // Collision done never arrives.
        rand_vel();
        set_stim(10'h3FF);
        launch(0);
        collide(0, 1, 0);
        updates(10'h000, 0, 100);
        check("timeout_done_cycle", rdone - r1, CT);
        check_flags();

        // Long stall with timer still running: tick lands mid-step.
        rand_vel();
        set_stim(10'h088);
        launch(1);
        collide(2, 0, 0);
        updates(10'h088, 15, 100);
        enable_in = 1'b0;
        if ((r1 - 1 + TP) <= rdone) m_ovr = 1;
        check_flags();
        for (int j = 0; j < TP + 2; j++) begin
            check("no_relaunch", busy_out, 0);
            clk_step();
        end

        // Standalone clear, then clear coincident with a latch.
        clear_in = 1'b1;
        clk_step();
        clear_in = 1'b0;
        m_hits = '0; m_tmo = 0; m_ovr = 0;
        check_flags();
        rand_vel();
        set_stim(10'h001);
        launch(0);
        collide(5, 0, 0);
        updates(10'h001, 0, 100);
        rand_vel();
        set_stim(10'h200);
        launch(0);
        collide(1, 0, 1);
        updates(10'h200, 0, 100);
        check("clear_new_hits_win", pins_hit_out, 10'h200);
        check_flags();

        // Randomized steps.
        for (int t = 0; t < 24; t++) begin
            logic [NUM_PINS-1:0] h;
            bit tmo, clr;
            int d;
            h = NUM_PINS'($urandom_range(0, 1023));
            if ($urandom_range(0, 4) == 0) h = '0;
            tmo = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 4) == 0);
            d = $urandom_range(0, CT - 1);
            rand_vel();
            set_stim(h);
            launch(0);
            collide(d, tmo, clr);
            updates(tmo ? '0 : h, 0, 60);
            check_flags();
        end

        // Reset in the middle of an update stall.
        rand_vel();
        set_stim(10'h0C0);
        launch(0);
        collide(1, 0, 0);
        upd_ready_in = 1'b0;
        clk_step();
        clk_step();
        check("valid_before_reset", upd_valid_out, 1);
        rst_in = 1'b0;
        #1;
        check_all_zero("midstep_reset");
        m_hits = '0; m_tmo = 0; m_ovr = 0;
        clk_step();
        rst_in = 1'b1;
        launch(0);
        collide(0, 0, 0);
        updates(10'h0C0, 0, 100);
        check_flags();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
